alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the ALU result mux (set-compare units, adders, logic units).
- Captures the ALU result S and flags Z/V/N together with destination-register info into a 2-entry skid buffer.
- Applies the signed-overflow trap rule and presents registered results to the memory/writeback stage over a valid/ready handshake.
- Isolates the combinational ALU path from the downstream stall path.

Parameters:
- DW, 32, ALU data width (S).
- RW, 5, register-address width.
- CW, 8, overflow-event counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty".
- alu_s  in  DW  ALU result S.
- alu_z  in  1  ALU zero flag.
- alu_v  in  1  ALU overflow flag.
- alu_n  in  1  ALU negative flag.
- trap_en  in  1  instruction traps on signed overflow (add/sub/addi with Sign=1).
- rd_addr  in  RW  destination register.
- reg_write  in  1  instruction writes rd.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_s  out  DW  head result.
- out_z  out  1  head zero flag.
- out_n  out  1  head negative flag.
- out_rd  out  RW  head destination.
- out_we  out  1  head write enable, already gated by trap.
- out_ovf  out  1  head entry raised an overflow trap.
- ovf_count  out  CW  saturating count of trapped entries delivered.

Behaviour:
- Reset: out_valid=0, in_ready=1, out_s=0, out_z=0, out_n=0, out_rd=0, out_we=0, out_ovf=0, ovf_count=0; both entries invalid.
- Reset asserted mid-operation discards both entries in that cycle.
- Storage: head register (drives out_*) and one skid register. State encoding: EMPTY (neither valid), ONE (head valid), TWO (head+skid valid).
- Accept: in_valid && in_ready && !flush.
- Pop: out_valid && out_ready && !flush.
- Transitions:
  - EMPTY + accept -> ONE, entry loads into head.
  - ONE + accept + pop -> ONE, head reloads.
  - ONE + accept, no pop -> TWO, entry loads into skid.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE, skid moves to head. No accept is possible in TWO because in_ready=0.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. The upstream stall therefore never depends combinationally on out_ready.
- Latency: accept in cycle t -> out_valid in cycle t+1. Sustained throughput is 1/cycle while out_ready=1.
- Trap rule, evaluated at accept:
  - ovf_hit = alu_v & trap_en.
  - Stored we = reg_write & ~ovf_hit; stored ovf = ovf_hit.
  - alu_v with trap_en=0 (unsigned ops) is ignored.
- out_z and out_n pass through unchanged; the stored result is not modified on trap.
- ovf_count increments on each pop with out_ovf=1 and saturates at 2^CW-1. Only reset clears it; flush does not.
- Flush:
  - Next cycle state is EMPTY with out_valid=0 and in_ready=1.
  - An in_valid in the same cycle is discarded.
  - A head with out_ready=1 in the same cycle is not counted as popped.
  - Flush has priority over accept and pop; reset has priority over flush.
- Data registers may hold stale values while invalid; only out_valid qualifies them. Exception: reset zeroes them.

Decomposition:
- Shared package holds the entry record typedef {s, z, n, rd, we, ovf}, the state encoding constants S_EMPTY/S_ONE/S_TWO, and the default widths.
- One natural sub-module: alu_ovf_gate, the combinational trap/write-enable gating applied to the incoming entry.
- The buffer and counter live in the top.

Test Plan:
1. Reset held 2 cycles, then released -> out_valid=0, in_ready=1, ovf_count=0, all out_* zero.
2. alu_s=0x0000_0001, rd=8, reg_write=1, out_ready=1 streamed 4 back-to-back cycles -> each appears one cycle later with out_we=1; in_ready stays 1.
3. out_ready=0, two accepts -> state TWO, in_ready=0 next cycle; third in_valid is not taken. out_ready=1 for 2 cycles -> both entries pop in order, in_ready returns to 1.
4. Overflow cases:
   - alu_s=0x8000_0000, alu_v=1, trap_en=1, reg_write=1 -> out_we=0, out_ovf=1; ovf_count 0->1 on pop.
   - Same with trap_en=0 -> out_we=1, out_ovf=0, count unchanged.
5. State TWO, then flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1; nothing delivered, ovf_count unchanged.
6. Preload ovf_count to 0xFF via 255 trapped pops, then one more -> stays 0xFF. Reset asserted in state TWO -> EMPTY and ovf_count=0 next cycle.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared types and default widths for the ALU result stage.
// The entry record is what each buffer slot holds after trap gating.
package alu_result_stage_pkg;

    localparam int unsigned ALU_DW = 32;
    localparam int unsigned ALU_RW = 5;
    localparam int unsigned ALU_CW = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ALU_DW-1:0] s;
        logic              z;
        logic              n;
        logic [ALU_RW-1:0] rd;
        logic              we;
        logic              ovf;
    } entry_t;

endpackage

// File: rtl/alu_ovf_gate.sv
// Signed-overflow trap gating for an incoming ALU result.
// Overflow counts only for signed ops; a trapped result never writes its destination.
module alu_ovf_gate (
    input  logic alu_v_i,
    input  logic trap_en_i,
    input  logic reg_write_i,
    output logic we_o,
    output logic ovf_o
);

    logic ovf_hit;

    assign ovf_hit = alu_v_i & trap_en_i;
    assign we_o    = reg_write_i & ~ovf_hit;
    assign ovf_o   = ovf_hit;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer with valid/ready on both sides,
// trap gating of the write enable and a saturating count of delivered traps.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned DW = ALU_DW,
    parameter int unsigned RW = ALU_RW,
    parameter int unsigned CW = ALU_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_s,
    input  logic          alu_z,
    input  logic          alu_v,
    input  logic          alu_n,
    input  logic          trap_en,
    input  logic [RW-1:0] rd_addr,
    input  logic          reg_write,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_s,
    output logic          out_z,
    output logic          out_n,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_ovf,
    output logic [CW-1:0] ovf_count
);

    state_e        state_q, state_d;
    entry_t        head_q, head_d;
    entry_t        skid_q, skid_d;
    entry_t        in_entry;
    logic          in_ready_q, in_ready_d;
    logic [CW-1:0] ovf_count_q, ovf_count_d;
    logic          accept, pop;
    logic          in_we, in_ovf;

    alu_ovf_gate u_ovf_gate (
        .alu_v_i     (alu_v),
        .trap_en_i   (trap_en),
        .reg_write_i (reg_write),
        .we_o        (in_we),
        .ovf_o       (in_ovf)
    );

    always_comb begin
        in_entry     = '0;
        in_entry.s   = alu_s;
        in_entry.z   = alu_z;
        in_entry.n   = alu_n;
        in_entry.rd  = rd_addr;
        in_entry.we  = in_we;
        in_entry.ovf = in_ovf;
    end

    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid && in_ready_q && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    head_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = S_TWO;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a pop can move the buffer.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    // Ready is derived from the next state so upstream never sees out_ready combinationally.
    assign in_ready_d = (state_d != S_TWO);

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (pop && head_q.ovf && (ovf_count_q != {CW{1'b1}})) begin
            ovf_count_d = ovf_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_s     = head_q.s;
    assign out_z     = head_q.z;
    assign out_n     = head_q.n;
    assign out_rd    = head_q.rd;
    assign out_we    = head_q.we;
    assign out_ovf   = head_q.ovf;
    assign ovf_count = ovf_count_q;

endmodule
